// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: operation classes, opcode constants and the
// record types passed between the decoder and the decode pipeline register.
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ALU    = 4'd1,
        OP_ALUI   = 4'd2,
        OP_LOAD   = 4'd3,
        OP_STORE  = 4'd4,
        OP_BRANCH = 4'd5,
        OP_JAL    = 4'd6,
        OP_JALR   = 4'd7,
        OP_LUI    = 4'd8,
        OP_AUIPC  = 4'd9,
        OP_CSR    = 4'd10,
        OP_SYSTEM = 4'd11
    } op_class_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // SYSTEM instructions with funct3==0 are only legal as these exact words
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    typedef struct packed {
        logic illegal;
        logic ecall;
        logic ebreak;
        logic mret;
    } flags_t;

    typedef struct packed {
        op_class_t   op_class;
        logic [31:0] imm;
        logic        rd_we;
        logic        uses_rs1;
        logic        uses_rs2;
        flags_t      flags;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd_addr;
        logic        rd_we;
        op_class_t   op_class;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [11:0] csr_addr;
    } fields_t;

    // Classes that produce a register-file result
    function automatic logic class_writes_rd(input op_class_t c);
        return c inside {OP_ALU, OP_ALUI, OP_LOAD, OP_JAL, OP_JALR,
                         OP_LUI, OP_AUIPC, OP_CSR};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I + Zicsr decoder: classifies the instruction,
// checks legality, builds the immediate and reports which sources it reads.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt, imm_z_fmt;

    assign opcode    = instr_i[6:0];
    assign f3        = instr_i[14:12];
    assign f7        = instr_i[31:25];
    assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_fmt = {instr_i[31:12], 12'h000};
    assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_z_fmt = {27'd0, instr_i[19:15]};

    // Opcode classification; anything not matched stays illegal (this also
    // covers instr[1:0] != 2'b11, since every opcode ends in 2'b11)
    always_comb begin
        dec_o       = '0;
        dec_o.op_class = OP_NOP;
        legal       = 1'b0;
        case (opcode)
            OPC_LUI:   begin legal = 1'b1; dec_o.op_class = OP_LUI;   dec_o.imm = imm_u_fmt; end
            OPC_AUIPC: begin legal = 1'b1; dec_o.op_class = OP_AUIPC; dec_o.imm = imm_u_fmt; end
            OPC_JAL:   begin legal = 1'b1; dec_o.op_class = OP_JAL;   dec_o.imm = imm_j_fmt; end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                dec_o.op_class = OP_JALR; dec_o.imm = imm_i_fmt; dec_o.uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                dec_o.op_class = OP_BRANCH; dec_o.imm = imm_b_fmt;
                dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                dec_o.op_class = OP_LOAD; dec_o.imm = imm_i_fmt; dec_o.uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                legal = !f3[2] && (f3[1:0] != 2'b11);
                dec_o.op_class = OP_STORE; dec_o.imm = imm_s_fmt;
                dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                dec_o.op_class = OP_ALUI; dec_o.imm = imm_i_fmt; dec_o.uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                dec_o.op_class = OP_ALU; dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE is a no-op in this in-order core
                legal = (f3 == 3'b000);
                dec_o.op_class = OP_NOP; dec_o.imm = imm_i_fmt;
            end
            OPC_SYSTEM: begin
                dec_o.imm = imm_i_fmt;
                if (f3 == 3'b000) begin
                    legal = 1'b1;
                    dec_o.op_class = OP_SYSTEM;
                    if (instr_i == INSTR_ECALL)       dec_o.flags.ecall  = 1'b1;
                    else if (instr_i == INSTR_EBREAK) dec_o.flags.ebreak = 1'b1;
                    else if (instr_i == INSTR_MRET)   dec_o.flags.mret   = 1'b1;
                    else if (instr_i == INSTR_WFI)    dec_o.op_class     = OP_NOP;
                    else                              legal = 1'b0;
                end else if (f3 != 3'b100) begin
                    legal = 1'b1;
                    dec_o.op_class = OP_CSR;
                    if (f3[2]) dec_o.imm = imm_z_fmt;
                    else       dec_o.uses_rs1 = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase

        // Illegal words carry nothing downstream except the illegal flag
        if (!legal) begin
            dec_o = '0;
            dec_o.op_class = OP_NOP;
            dec_o.flags.illegal = 1'b1;
        end
        dec_o.rd_we = legal && (instr_i[11:7] != 5'd0) && class_writes_rd(dec_o.op_class);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: register-file address generation, load-use hazard
// detection and the decode->execute register with flush/stall/bubble control.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned HAZARD_EN = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output op_class_t   op_class_o,
    output logic [2:0]  funct3_o,
    output logic        funct7b5_o,
    output logic [11:0] csr_addr_o,
    output logic        illegal_o,
    output logic        ecall_o,
    output logic        ebreak_o,
    output logic        mret_o
);

    dec_t    dec;
    fields_t fields_q, fields_d;
    flags_t  flags_q, flags_d;
    logic    valid_q, valid_d;
    logic    armed_q;   // low only until the first edge after reset release
    logic    rs1_hit, rs2_hit, hazard;

    instr_decoder u_dec (
        .instr_i (instr_i),
        .dec_o   (dec)
    );

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    // Load-use hazard: the load in the output register writes a source of instr_i
    always_comb begin
        rs1_hit = dec.uses_rs1 && (instr_i[19:15] == fields_q.rd_addr);
        rs2_hit = dec.uses_rs2 && (instr_i[24:20] == fields_q.rd_addr);
        hazard  = (HAZARD_EN != 0) && valid_i && valid_q &&
                  (fields_q.op_class == OP_LOAD) && (fields_q.rd_addr != 5'd0) &&
                  (rs1_hit || rs2_hit);
    end

    assign stall_o = hazard && !flush_i;

    // Next output register: flush > stall > hazard bubble > capture; fields
    // only change on a valid capture, flags drop whenever valid drops
    always_comb begin
        fields_d = fields_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (!armed_q || flush_i) begin
            valid_d = 1'b0;
            flags_d = '0;
        end else if (!stall_i) begin
            if (hazard || !valid_i) begin
                valid_d = 1'b0;
                flags_d = '0;
            end else begin
                valid_d           = 1'b1;
                flags_d           = dec.flags;
                fields_d.pc       = pc_i;
                fields_d.rs1_data = rs1_data_i;
                fields_d.rs2_data = rs2_data_i;
                fields_d.imm      = dec.imm;
                fields_d.rd_addr  = instr_i[11:7];
                fields_d.rd_we    = dec.rd_we;
                fields_d.op_class = dec.op_class;
                fields_d.funct3   = instr_i[14:12];
                fields_d.funct7b5 = instr_i[30];
                fields_d.csr_addr = instr_i[31:20];
            end
        end
    end

    // Output register with asynchronous clear (op_class clears to OP_NOP = 0)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fields_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            fields_q <= fields_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            armed_q  <= 1'b1;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = fields_q.pc;
    assign rs1_data_o = fields_q.rs1_data;
    assign rs2_data_o = fields_q.rs2_data;
    assign imm_o      = fields_q.imm;
    assign rd_addr_o  = fields_q.rd_addr;
    assign rd_we_o    = fields_q.rd_we;
    assign op_class_o = fields_q.op_class;
    assign funct3_o   = fields_q.funct3;
    assign funct7b5_o = fields_q.funct7b5;
    assign csr_addr_o = fields_q.csr_addr;
    assign illegal_o  = flags_q.illegal;
    assign ecall_o    = flags_q.ecall;
    assign ebreak_o   = flags_q.ebreak;
    assign mret_o     = flags_q.mret;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i, valid_i, stall_i, flush_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;

    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        stall_o, valid_o, rd_we_o, funct7b5_o, illegal_o, ecall_o, ebreak_o, mret_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    op_class_t   op_class_o;
    logic [2:0]  funct3_o;
    logic [11:0] csr_addr_o;

    logic [4:0]  nh_rs1_addr, nh_rs2_addr, nh_rd_addr;
    logic        nh_stall, nh_valid, nh_rd_we, nh_f7b5, nh_ill, nh_ecall, nh_ebreak, nh_mret;
    logic [31:0] nh_pc, nh_rs1_data, nh_rs2_data, nh_imm;
    op_class_t   nh_cls;
    logic [2:0]  nh_f3;
    logic [11:0] nh_csr;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    decode_stage #(.HAZARD_EN(1)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_o(stall_o), .valid_o(valid_o),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .op_class_o(op_class_o), .funct3_o(funct3_o),
        .funct7b5_o(funct7b5_o), .csr_addr_o(csr_addr_o), .illegal_o(illegal_o),
        .ecall_o(ecall_o), .ebreak_o(ebreak_o), .mret_o(mret_o));

    decode_stage #(.HAZARD_EN(0)) dut_nh (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i), .rs1_addr_o(nh_rs1_addr), .rs2_addr_o(nh_rs2_addr),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_o(nh_stall), .valid_o(nh_valid),
        .pc_o(nh_pc), .rs1_data_o(nh_rs1_data), .rs2_data_o(nh_rs2_data), .imm_o(nh_imm),
        .rd_addr_o(nh_rd_addr), .rd_we_o(nh_rd_we), .op_class_o(nh_cls), .funct3_o(nh_f3),
        .funct7b5_o(nh_f7b5), .csr_addr_o(nh_csr), .illegal_o(nh_ill),
        .ecall_o(nh_ecall), .ebreak_o(nh_ebreak), .mret_o(nh_mret));

    // ---------------- behavioural reference ----------------
    typedef enum {F_NONE, F_I, F_S, F_B, F_U, F_J, F_Z} fmt_e;
    typedef struct packed {
        logic        legal;
        op_class_t   cls;
        logic [31:0] imm;
        logic        we, u1, u2, ec, eb, mr;
    } rdec_t;

    function automatic rdec_t ref_decode(input logic [31:0] w);
        rdec_t r;
        fmt_e  fmt;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        f3 = w[14:12];
        f7 = w[31:25];
        r.legal = 1'b0; r.cls = OP_NOP; r.imm = 32'd0;
        r.we = 1'b0; r.u1 = 1'b0; r.u2 = 1'b0; r.ec = 1'b0; r.eb = 1'b0; r.mr = 1'b0;
        fmt = F_NONE;
        case (w[6:0])
            7'h37: begin r.legal = 1; r.cls = OP_LUI;   fmt = F_U; end
            7'h17: begin r.legal = 1; r.cls = OP_AUIPC; fmt = F_U; end
            7'h6F: begin r.legal = 1; r.cls = OP_JAL;   fmt = F_J; end
            7'h67: begin r.legal = (f3 == 0); r.cls = OP_JALR; fmt = F_I; r.u1 = 1; end
            7'h63: begin r.legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
                         r.cls = OP_BRANCH; fmt = F_B; r.u1 = 1; r.u2 = 1; end
            7'h03: begin r.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                         r.cls = OP_LOAD; fmt = F_I; r.u1 = 1; end
            7'h23: begin r.legal = f3 inside {3'd0, 3'd1, 3'd2};
                         r.cls = OP_STORE; fmt = F_S; r.u1 = 1; r.u2 = 1; end
            7'h13: begin
                if (f3 == 1)      r.legal = (f7 == 0);
                else if (f3 == 5) r.legal = (f7 == 0) || (f7 == 7'h20);
                else              r.legal = 1;
                r.cls = OP_ALUI; fmt = F_I; r.u1 = 1;
            end
            7'h33: begin r.legal = (f7 == 0) || ((f7 == 7'h20) && (f3 == 0 || f3 == 5));
                         r.cls = OP_ALU; r.u1 = 1; r.u2 = 1; end
            7'h0F: begin r.legal = (f3 == 0); r.cls = OP_NOP; fmt = F_I; end
            7'h73: begin
                fmt = F_I;
                if (w == 32'h0000_0073)      begin r.legal = 1; r.cls = OP_SYSTEM; r.ec = 1; end
                else if (w == 32'h0010_0073) begin r.legal = 1; r.cls = OP_SYSTEM; r.eb = 1; end
                else if (w == 32'h3020_0073) begin r.legal = 1; r.cls = OP_SYSTEM; r.mr = 1; end
                else if (w == 32'h1050_0073) begin r.legal = 1; r.cls = OP_NOP; end
                else if (f3 inside {3'd1, 3'd2, 3'd3}) begin r.legal = 1; r.cls = OP_CSR; r.u1 = 1; end
                else if (f3 inside {3'd5, 3'd6, 3'd7}) begin r.legal = 1; r.cls = OP_CSR; fmt = F_Z; end
            end
            default: r.legal = 1'b0;
        endcase
        s12 = w[31:20];
        case (fmt)
            F_I: r.imm = 32'(s12);
            F_S: begin s12 = {w[31:25], w[11:7]}; r.imm = 32'(s12); end
            F_B: begin s13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r.imm = 32'(s13); end
            F_U: r.imm = w & 32'hFFFF_F000;
            F_J: begin s21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r.imm = 32'(s21); end
            F_Z: r.imm = 32'(w[19:15]);
            default: r.imm = 32'd0;
        endcase
        if (!r.legal) begin
            r.cls = OP_NOP; r.imm = 0; r.u1 = 0; r.u2 = 0; r.ec = 0; r.eb = 0; r.mr = 0;
        end
        r.we = r.legal && (w[11:7] != 0) &&
               (r.cls inside {OP_ALU, OP_ALUI, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_CSR});
        return r;
    endfunction

    // model of the output register contents
    logic        m_valid, m_we, m_f7b5, m_ill, m_ec, m_eb, m_mr, m_first;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rd;
    op_class_t   m_cls;
    logic [2:0]  m_f3;
    logic [11:0] m_csr;
    logic        last_stall, last_nh_stall;

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_f7b5 = 0; m_ill = 0; m_ec = 0; m_eb = 0; m_mr = 0;
        m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_rd = 0; m_cls = OP_NOP; m_f3 = 0; m_csr = 0;
        m_first = 1;
    endtask

    function automatic logic model_hazard();
        rdec_t d;
        d = ref_decode(instr_i);
        return m_valid && valid_i && (m_cls == OP_LOAD) && (m_rd != 0) &&
               ((d.u1 && instr_i[19:15] == m_rd) || (d.u2 && instr_i[24:20] == m_rd));
    endfunction

    task automatic model_clock();
        rdec_t d;
        logic  haz;
        d   = ref_decode(instr_i);
        haz = model_hazard();
        if (m_first || flush_i) begin
            m_valid = 0; m_ill = 0; m_ec = 0; m_eb = 0; m_mr = 0;
        end else if (stall_i) begin
            m_valid = m_valid;
        end else if (haz || !valid_i) begin
            m_valid = 0; m_ill = 0; m_ec = 0; m_eb = 0; m_mr = 0;
        end else begin
            m_valid = 1; m_pc = pc_i; m_d1 = rs1_data_i; m_d2 = rs2_data_i;
            m_imm = d.imm; m_rd = instr_i[11:7]; m_we = d.we; m_cls = d.cls;
            m_f3 = instr_i[14:12]; m_f7b5 = instr_i[30]; m_csr = instr_i[31:20];
            m_ill = !d.legal; m_ec = d.ec; m_eb = d.eb; m_mr = d.mr;
        end
        m_first = 0;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_comb();
        chk("rs1_addr", 32'(rs1_addr_o), 32'(instr_i[19:15]));
        chk("rs2_addr", 32'(rs2_addr_o), 32'(instr_i[24:20]));
        chk("stall", 32'(stall_o), 32'(model_hazard() && !flush_i));
        chk("nh_stall", 32'(nh_stall), 32'd0);
        last_stall    = stall_o;
        last_nh_stall = nh_stall;
    endtask

    task automatic check_regs();
        chk("valid", 32'(valid_o), 32'(m_valid));
        chk("pc", pc_o, m_pc);
        chk("rs1_data", rs1_data_o, m_d1);
        chk("rs2_data", rs2_data_o, m_d2);
        chk("imm", imm_o, m_imm);
        chk("rd_addr", 32'(rd_addr_o), 32'(m_rd));
        chk("rd_we", 32'(rd_we_o), 32'(m_we));
        chk("op_class", 32'(op_class_o), 32'(m_cls));
        chk("funct3", 32'(funct3_o), 32'(m_f3));
        chk("funct7b5", 32'(funct7b5_o), 32'(m_f7b5));
        chk("csr_addr", 32'(csr_addr_o), 32'(m_csr));
        chk("illegal", 32'(illegal_o), 32'(m_ill));
        chk("ecall", 32'(ecall_o), 32'(m_ec));
        chk("ebreak", 32'(ebreak_o), 32'(m_eb));
        chk("mret", 32'(mret_o), 32'(m_mr));
    endtask

    // one clock: combinational checks before the edge, register checks after
    task automatic step();
        #1;
        check_comb();
        @(posedge clk_i);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic st, input logic fl);
        valid_i = v; instr_i = w; pc_i = pc; stall_i = st; flush_i = fl;
        rs1_data_i = $urandom; rs2_data_i = $urandom;
    endtask

    logic [6:0]  opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                  7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] sys_tab [4]  = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h1050_0073};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  ra, rb, rc;
        w  = $urandom;
        ra = 5'($urandom_range(0, 3));
        rb = 5'($urandom_range(0, 3));
        rc = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0: return w;
            1, 2: return {w[31:20], ra, 3'b010, rc, 7'h03};
            3: return {7'h00, rb, ra, 3'b000, rc, 7'h33};
            4: return {w[31:25], rb, ra, 3'b010, w[11:7], 7'h23};
            5: return {w[31:25], rb, ra, 3'b000, w[11:7], 7'h63};
            6: return sys_tab[$urandom_range(0, 3)];
            7: return {w[31:20], ra, w[14:12], rc, 7'h73};
            default: return {w[31:20], ra, w[14:12], rc, opc_tab[$urandom_range(0, 10)]};
        endcase
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 0;
        drive(0, 32'h0, 32'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_regs();
        chk("reset_opclass_nop", 32'(op_class_o), 32'(OP_NOP));
        rstn_i = 1;

        // first edge after release
        drive(1, 32'h0050_0093, 32'h8000_0000, 0, 0);
        step();
        chk("first_edge_valid0", 32'(valid_o), 32'd0);

        // addi x1,x0,5
        drive(1, 32'h0050_0093, 32'h8000_0000, 0, 0);
        step();
        chk("addi_valid", 32'(valid_o), 32'd1);
        chk("addi_imm", imm_o, 32'd5);
        chk("addi_rd", 32'(rd_addr_o), 32'd1);
        chk("addi_we", 32'(rd_we_o), 32'd1);
        chk("addi_cls", 32'(op_class_o), 32'(OP_ALUI));
        chk("addi_pc", pc_o, 32'h8000_0000);

        // lw x2,0(x1) then add x3,x2,x2: one stall, one bubble, then the add
        drive(1, 32'h0000_A103, 32'h8000_0004, 0, 0);
        step();
        chk("lw_cls", 32'(op_class_o), 32'(OP_LOAD));
        drive(1, 32'h0021_01B3, 32'h8000_0008, 0, 0);
        step();
        chk("lu_stall", 32'(last_stall), 32'd1);
        chk("lu_nh_stall", 32'(last_nh_stall), 32'd0);
        chk("lu_bubble", 32'(valid_o), 32'd0);
        step();
        chk("lu_stall_drop", 32'(last_stall), 32'd0);
        chk("lu_add_valid", 32'(valid_o), 32'd1);
        chk("lu_add_rd", 32'(rd_addr_o), 32'd3);
        chk("lu_add_pc", pc_o, 32'h8000_0008);

        // illegal words and mret
        drive(1, 32'hFFFF_FFFF, 32'h10, 0, 0);
        step();
        chk("ffff_illegal", 32'(illegal_o), 32'd1);
        chk("ffff_we", 32'(rd_we_o), 32'd0);
        drive(1, 32'h0000_0000, 32'h14, 0, 0);
        step();
        chk("zero_illegal", 32'(illegal_o), 32'd1);
        chk("zero_we", 32'(rd_we_o), 32'd0);
        drive(1, 32'h3020_0073, 32'h18, 0, 0);
        step();
        chk("mret_flag", 32'(mret_o), 32'd1);
        chk("mret_we", 32'(rd_we_o), 32'd0);

        // flush and stall together kill a valid output
        drive(1, 32'h0000_0000, 32'h1C, 1, 1);
        step();
        chk("flush_stall_valid", 32'(valid_o), 32'd0);
        chk("flush_flags", 32'(illegal_o | mret_o), 32'd0);

        // stall alone for three cycles holds everything
        drive(1, 32'hFFF3_0293, 32'h100, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_instr(), $urandom, 1, 0);
            step();
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_imm", imm_o, 32'hFFFF_FFFF);
            chk("hold_rd", 32'(rd_addr_o), 32'd5);
            chk("hold_pc", pc_o, 32'h100);
        end

        // lw x0 then add reading x0: no hazard
        drive(1, 32'h0000_A003, 32'h200, 0, 0);
        step();
        chk("lwx0_we", 32'(rd_we_o), 32'd0);
        drive(1, 32'h0000_01B3, 32'h204, 0, 0);
        step();
        chk("lwx0_nostall", 32'(last_stall), 32'd0);
        chk("lwx0_add_valid", 32'(valid_o), 32'd1);

        random_phase(1500);

        // reset pulsed mid-stream
        drive(1, 32'h0050_0093, 32'h300, 0, 0);
        #2;
        rstn_i = 0;
        #1;
        model_reset();
        check_regs();
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_pc", pc_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1;
        step();
        chk("midrst_first_edge", 32'(valid_o), 32'd0);
        step();
        chk("midrst_resume", 32'(valid_o), 32'd1);

        random_phase(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
